lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the byte-RAM load/store controller.
package lsu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store controller: splits byte and 16-bit CPU accesses into byte-RAM
// cycles and assembles little-endian load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int BYTE_SEXT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [WORD_W-DATA_W-1:0] ext;

    assign ext       = (BYTE_SEXT != 0) ? {(WORD_W-DATA_W){ram_q[DATA_W-1]}} : '0;
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_DONE) && !rst;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        word_d  = word_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        ram_a   = '0;
        ram_d   = '0;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    word_d  = req_word;
                    state_d = ST_ACC0;
                end
            end
            ST_ACC0: begin
                ram_a  = addr_q;
                ram_d  = wdata_q[DATA_W-1:0];
                ram_we = we_q;
                ram_re = !we_q;
                if (word_q) begin
                    state_d = ST_ACC1;
                end else if (we_q) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACC1: begin
                ram_a  = addr_q + 1'b1;
                ram_d  = wdata_q[WORD_W-1:DATA_W];
                ram_we = we_q;
                ram_re = !we_q;
                if (we_q) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    lo_d    = ram_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = word_q ? {ram_q, lo_q} : {ext, ram_q};
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Reset suppresses the RAM cycle in flight so an interrupted store
        // never commits its pending byte.
        if (rst) begin
            ram_a  = '0;
            ram_d  = '0;
            ram_re = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            word_q  <= word_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
